// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver that packs DATA_WIDTH/8 bytes (LSB byte
// first) into one word and queues completed words in a first-word-fall-through
// FIFO.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on the synchronized rx
// START | timing to mid start bit; a high level there is a glitch
// DATA  | sampling eight data bits at bit centre, LSB first
// STOP  | sampling the stop bit; high accepts the byte, low is a frame error
module uart_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int NTICKS     = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  input  logic [10:0]           divisor,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  rx_empty,
  output logic                  rx_full,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SW     = $clog2(NTICKS);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  localparam logic [SW-1:0] S_MID  = SW'(NTICKS / 2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(NTICKS - 1);
  localparam logic [BW-1:0] K_LAST = BW'(NBYTES - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                  rx_meta;
  logic                  rx_sync;
  logic [10:0]           baud_cnt;
  logic                  tick;
  state_t                state;
  logic [SW-1:0]         s_cnt;
  logic [2:0]            n_cnt;
  logic [7:0]            byte_reg;
  logic [DATA_WIDTH-1:0] word_reg;
  logic [BW-1:0]         k_cnt;
  logic                  stop_sample;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_word;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_pop;
  logic                  do_push;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Wrap on >= so that a divisor lowered mid-count cannot strand the counter.
  assign tick = (divisor != 11'd0) && (baud_cnt >= divisor - 11'd1);

  // Baud tick counter: one tick every divisor clocks, none when divisor is 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
    end else if (divisor == 11'd0 || tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 11'd1;
    end
  end

  assign stop_sample = (state == STOP) && tick && (s_cnt == S_END);
  assign push        = stop_sample && rx_sync && (k_cnt == K_LAST);

  // Partial word with the just-finished byte dropped into its slot.
  always_comb begin
    push_word = word_reg;
    for (int b = 0; b < NBYTES; b++) begin
      if (k_cnt == BW'(b)) push_word[8*b +: 8] = byte_reg;
    end
  end

  // Receive FSM, byte assembly and the registered frame error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      s_cnt     <= '0;
      n_cnt     <= '0;
      byte_reg  <= '0;
      word_reg  <= '0;
      k_cnt     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == S_MID) begin
              s_cnt <= '0;
              if (!rx_sync) begin
                state <= DATA;
                n_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt == S_END) begin
              s_cnt    <= '0;
              byte_reg <= {rx_sync, byte_reg[7:1]};
              if (n_cnt == 3'd7) state <= STOP;
              else n_cnt <= n_cnt + 3'd1;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_cnt == S_END) begin
              s_cnt <= '0;
              state <= IDLE;
              if (rx_sync) begin
                if (k_cnt == K_LAST) begin
                  k_cnt    <= '0;
                  word_reg <= '0;
                end else begin
                  k_cnt    <= k_cnt + 1'b1;
                  word_reg <= push_word;
                end
              end else begin
                // A bad stop bit throws away the whole word in progress.
                frame_err <= 1'b1;
                k_cnt     <= '0;
                word_reg  <= '0;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign do_pop  = rden && (count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && ((count != C_FULL) || do_pop);

  // Word FIFO storage, pointers, occupancy and the registered overrun pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && !do_push;
      if (do_push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign r_data   = mem[rd_ptr];
  assign rx_empty = (count == '0);
  assign rx_full  = (count == C_FULL);

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the APB-UART bridge, the receiving end of the 32-bit-word UART transmitter link. It oversamples the `rx` line at NTICKS ticks per bit, using the same 11-bit `divisor` baud generator as the transmitter. It deserializes four consecutive 8N1 byte frames (least-significant byte first) into one DATA_WIDTH word and buffers completed words in a small first-word-fall-through FIFO for the bus side to read.

## Interface
- DATA_WIDTH, 32, received word width; must be a multiple of 8 (bytes per word = DATA_WIDTH/8)
- FIFO_DEPTH, 4, word FIFO entries; power of two
- NTICKS, 16, oversampling ticks per bit
- clk  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rx  in  1  serial input; idle high; asynchronous to clk
- divisor  in  11  baud tick period in clk cycles
- rden  in  1  pop request for the FIFO head word
- r_data  out  DATA_WIDTH  FIFO head word (first-word fall-through)
- rx_empty  out  1  FIFO holds no words
- rx_full  out  1  FIFO holds FIFO_DEPTH words
- frame_err  out  1  one-cycle pulse when a stop bit is sampled low
- overrun  out  1  one-cycle pulse when a completed word is dropped because the FIFO is full

## Operation
- `rx` passes through a 2-flop synchronizer with both flops reset to 1. All sampling uses the synchronized value.
- **Tick generator:** counter runs 0..divisor-1 and pulses `tick` for one cycle at divisor-1, giving one tick every `divisor` clocks. `divisor`=0 produces no ticks and freezes the FSM.
- **FSM states:** IDLE, START, DATA, STOP. Tick counter s (0..NTICKS-1) and bit counter n (0..7).
  - IDLE: synchronized rx = 0 -> START, s=0.
  - START: on tick, at s = NTICKS/2-1 sample rx. If rx = 0 -> DATA, s=0, n=0. If rx = 1 -> IDLE as a glitch, with no error flagged.
  - DATA: on tick, at s = NTICKS-1 shift rx into the byte MSB (LSB-first reception) and set s=0. At n = 7 -> STOP.
  - STOP: on tick, at s = NTICKS-1 sample rx.
    - rx = 1: byte accepted -> IDLE.
    - rx = 0: assert `frame_err` for one cycle, discard the byte and any partial word, clear the byte counter -> IDLE.
- **Word assembly:** byte k (k = 0..DATA_WIDTH/8-1) lands in bits [8k+7:8k]. The byte counter wraps to 0 after the last byte, and the completed word is pushed in that same cycle.
- **FIFO rules:**
  - Push when not full: word stored.
  - Push when full and no pop: word dropped, `overrun` pulses for one cycle, FIFO contents unchanged.
  - Push and `rden` in the same cycle while full: pop and push both succeed. Count unchanged, no overrun.
  - Push and `rden` in the same cycle while empty: only the push takes effect. Pop on empty is ignored.
  - `rden` on non-empty: head advances next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- **Reset values** (asynchronous, immediate, including mid-frame):
  - FSM = IDLE; all counters = 0; FIFO pointers and count = 0.
  - `r_data` = 0, `rx_empty` = 1, `rx_full` = 0, `frame_err` = 0, `overrun` = 0.
  - After reset release, any partially received frame is lost. The FSM re-arms on the next falling edge of the synchronized `rx`.

## Timing
- rx edge to the synchronized value: 2 clk cycles.
- Bit period = divisor*NTICKS clocks. Data bits are sampled near the bit centre: the start bit at NTICKS/2 ticks after its detected edge, each later bit NTICKS ticks after the previous sample.
- The push occurs in the clock cycle of the final stop-bit sample. `r_data`, `rx_empty` and `rx_full` update on the next rising edge.
- `frame_err` and `overrun` are registered, high for exactly one cycle, and coincide with the cycle after the stop sample.
- After `rden`, `r_data` shows the next word one cycle later.
- Back-to-back frames are received with no idle gap required. The FSM is in IDLE at mid-stop-bit and can detect the next start edge.

## Test plan
- **Single word:** divisor=10 (bit = 160 clk); send 32'h5F0A3E1D as bytes 1D,3E,0A,5F, 8N1, no gaps -> rx_empty falls about 4×10×160 clk after the first start edge; r_data = 32'h5F0A3E1D; frame_err = 0 and overrun = 0 throughout.
- **Fill and overrun:** send 32'hF9E3A117, 32'h13C5A27D, 32'h27C00743, 32'h11223344, then 32'hAABBCCDD with rden = 0 -> rx_full = 1 after the 4th word; a single overrun pulse on the 5th; popping four times returns the first four words in order, then rx_empty = 1.
- **Frame error:** send byte 0x1D with a good stop bit, then byte 0x3E with a stop bit of 0 -> one frame_err pulse. Then send a full word 32'h01020304 -> r_data = 32'h01020304, showing the partial word was discarded.
- **Glitch:** drive rx low for 3×divisor clk, then high -> no state change, no byte counted, no flags.
- **Full with simultaneous pop:** with the FIFO full, assert rden in the push cycle of a 5th word -> no overrun; count stays 4; the oldest word is removed and the newest is stored at the tail.
- **Reset mid-frame:** assert reset_n = 0 during the DATA bits of byte 2 -> all outputs take their reset values at once. After release, a fresh word 32'hDEADBEEF is received correctly.
